// File: rtl/mem_port_arbiter.sv
// Shares one external bus port between the instruction-fetch (I) and load/store (D) masters,
// using a registered grant FSM with round-robin tie-break. Define ARB_TIMEOUT_EN to add the grant timeout.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMR_W          = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] iadr_i,
  input  logic [1:0]  isiz_i,
  output logic        iack_o,
  output logic [31:0] idat_o,
  output logic        ierr_o,
  input  logic [63:0] dadr_i,
  input  logic [1:0]  dsiz_i,
  input  logic        dwe_i,
  input  logic [63:0] ddat_i,
  output logic        dack_o,
  output logic [63:0] ddat_o,
  output logic        derr_o,
  output logic [63:0] madr_o,
  output logic [1:0]  msiz_o,
  output logic        mwe_o,
  output logic [63:0] mdat_o,
  input  logic        mack_i,
  input  logic [63:0] mdat_i,
  output logic [1:0]  owner_o
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_OWN_I = 2'b01;
  localparam logic [1:0] ST_OWN_D = 2'b10;

  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_last;
  logic       w_last_nxt;

  logic w_ireq;
  logic w_dreq;
  logic w_own_i;
  logic w_own_d;
  logic w_owned;
  logic w_own_req;
  logic w_withdraw;
  logic w_done;
  logic w_expire;

  assign w_ireq     = (isiz_i != 2'b00);
  assign w_dreq     = (dsiz_i != 2'b00);
  assign w_own_i    = (r_state == ST_OWN_I);
  assign w_own_d    = (r_state == ST_OWN_D);
  assign w_owned    = w_own_i | w_own_d;
  assign w_own_req  = w_own_i ? w_ireq : w_dreq;
  // Withdrawal beats both ack and timeout: the owner no longer wants the transfer.
  assign w_withdraw = w_owned & ~w_own_req;
  assign w_done     = w_owned & ~w_withdraw & mack_i;

`ifdef ARB_TIMEOUT_EN
  logic [TMR_W-1:0] r_tmr;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_tmr <= '0;
    end else if (r_state == ST_IDLE) begin
      r_tmr <= '0;
    end else if (!mack_i) begin
      r_tmr <= r_tmr + TMR_W'(1);
    end
  end

  // An ack arriving in the expiry cycle wins, so expiry requires mack_i low.
  assign w_expire = w_owned & ~w_withdraw & ~mack_i &
                    (r_tmr == TMR_W'(TIMEOUT_CYCLES));
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_ireq && w_dreq) begin
          w_state_nxt = (r_last == LAST_D) ? ST_OWN_I : ST_OWN_D;
        end else if (w_ireq) begin
          w_state_nxt = ST_OWN_I;
        end else if (w_dreq) begin
          w_state_nxt = ST_OWN_D;
        end
      end
      ST_OWN_I: begin
        if (w_withdraw) begin
          w_state_nxt = ST_IDLE;
        end else if (w_done || w_expire) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = LAST_I;
        end
      end
      ST_OWN_D: begin
        if (w_withdraw) begin
          w_state_nxt = ST_IDLE;
        end else if (w_done || w_expire) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = LAST_D;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_last  <= LAST_D;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    madr_o = '0;
    msiz_o = 2'b00;
    mwe_o  = 1'b0;
    mdat_o = '0;
    iack_o = 1'b0;
    dack_o = 1'b0;
    ierr_o = 1'b0;
    derr_o = 1'b0;
    case (r_state)
      ST_OWN_I: begin
        madr_o = iadr_i;
        msiz_o = isiz_i;
        iack_o = w_done;
        ierr_o = w_expire;
      end
      ST_OWN_D: begin
        madr_o = dadr_i;
        msiz_o = dsiz_i;
        mwe_o  = dwe_i;
        mdat_o = ddat_i;
        dack_o = w_done;
        derr_o = w_expire;
      end
      default: begin
      end
    endcase
  end

  assign idat_o  = mdat_i[31:0];
  assign ddat_o  = mdat_i;
  assign owner_o = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic against a transfer-level model.
module tb_mem_port_arbiter;

  localparam int unsigned TO = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [63:0] iadr_i;
  logic [1:0]  isiz_i;
  logic        iack_o;
  logic [31:0] idat_o;
  logic        ierr_o;
  logic [63:0] dadr_i;
  logic [1:0]  dsiz_i;
  logic        dwe_i;
  logic [63:0] ddat_i;
  logic        dack_o;
  logic [63:0] ddat_o;
  logic        derr_o;
  logic [63:0] madr_o;
  logic [1:0]  msiz_o;
  logic        mwe_o;
  logic [63:0] mdat_o;
  logic        mack_i;
  logic [63:0] mdat_i;
  logic [1:0]  owner_o;

  int checks   = 0;
  int failures = 0;

  // Model: who holds the port (0 none, 1 I, 2 D), who was served last, cycles waited.
  int m_owner;
  int m_last;
  int m_wait;
  bit g_iack, g_dack, g_ierr, g_derr;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .TMR_W(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .iadr_i(iadr_i), .isiz_i(isiz_i), .iack_o(iack_o), .idat_o(idat_o), .ierr_o(ierr_o),
    .dadr_i(dadr_i), .dsiz_i(dsiz_i), .dwe_i(dwe_i), .ddat_i(ddat_i),
    .dack_o(dack_o), .ddat_o(ddat_o), .derr_o(derr_o),
    .madr_o(madr_o), .msiz_o(msiz_o), .mwe_o(mwe_o), .mdat_o(mdat_o),
    .mack_i(mack_i), .mdat_i(mdat_i), .owner_o(owner_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at negedge with inputs applied: check outputs, advance the model, move to next negedge.
  task automatic tick();
    logic [63:0] e_adr, e_mdat;
    logic [1:0]  e_siz;
    logic        e_we, e_iack, e_dack, e_ierr, e_derr;
    bit          wd, expire;
    #1;
    e_adr = '0; e_mdat = '0; e_siz = 2'b00; e_we = 1'b0;
    e_iack = 1'b0; e_dack = 1'b0; e_ierr = 1'b0; e_derr = 1'b0;
    wd = 1'b0; expire = 1'b0;
    if (m_owner == 1) begin
      e_adr  = iadr_i;
      e_siz  = isiz_i;
      wd     = (isiz_i == 2'b00);
      expire = TMO && !mack_i && !wd && (m_wait == TO);
      e_iack = mack_i && !wd;
      e_ierr = expire;
    end else if (m_owner == 2) begin
      e_adr  = dadr_i;
      e_siz  = dsiz_i;
      e_we   = dwe_i;
      e_mdat = ddat_i;
      wd     = (dsiz_i == 2'b00);
      expire = TMO && !mack_i && !wd && (m_wait == TO);
      e_dack = mack_i && !wd;
      e_derr = expire;
    end
    chk("owner", 64'(owner_o), 64'(m_owner));
    chk("madr", madr_o, e_adr);
    chk("msiz", 64'(msiz_o), 64'(e_siz));
    chk("mwe", 64'(mwe_o), 64'(e_we));
    chk("mdat", mdat_o, e_mdat);
    chk("iack", 64'(iack_o), 64'(e_iack));
    chk("dack", 64'(dack_o), 64'(e_dack));
    chk("ierr", 64'(ierr_o), 64'(e_ierr));
    chk("derr", 64'(derr_o), 64'(e_derr));
    chk("idat", 64'(idat_o), 64'(mdat_i[31:0]));
    chk("ddat", ddat_o, mdat_i);
    g_iack = e_iack; g_dack = e_dack; g_ierr = e_ierr; g_derr = e_derr;
    if (reset_i) begin
      m_owner = 0; m_last = 2; m_wait = 0;
    end else if (m_owner == 0) begin
      m_wait = 0;
      if (isiz_i != 2'b00 && dsiz_i != 2'b00) m_owner = (m_last == 2) ? 1 : 2;
      else if (isiz_i != 2'b00) m_owner = 1;
      else if (dsiz_i != 2'b00) m_owner = 2;
    end else begin
      if (!mack_i) m_wait++;
      if (wd) m_owner = 0;
      else if (mack_i || expire) begin
        m_last  = m_owner;
        m_owner = 0;
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    reset_i = 1'b1;
    iadr_i = '0; isiz_i = 2'b00; dadr_i = '0; dsiz_i = 2'b00; dwe_i = 1'b0; ddat_i = '0;
    mack_i = 1'b0; mdat_i = '0;
    m_owner = 0; m_last = 2; m_wait = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    tick();

    // Single I read
    reset_i = 1'b0;
    isiz_i = 2'b10; iadr_i = 64'hFFFF_FFFF_FFFF_FF00;
    tick();
    #1;
    chk("t1_owner", 64'(owner_o), 64'h1);
    chk("t1_madr", madr_o, 64'hFFFF_FFFF_FFFF_FF00);
    chk("t1_msiz", 64'(msiz_o), 64'h2);
    mack_i = 1'b1; mdat_i = 64'h0000_0013;
    #1;
    chk("t1_iack", 64'(iack_o), 64'h1);
    chk("t1_idat", 64'(idat_o), 64'h13);
    tick();
    isiz_i = 2'b00; mack_i = 1'b0;
    #1;
    chk("t1_idle", 64'(owner_o), 64'h0);

    // Simultaneous requests out of reset
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    iadr_i = 64'h124; isiz_i = 2'b10;
    dadr_i = 64'h248; dsiz_i = 2'b11; dwe_i = 1'b1; ddat_i = 64'hDEAD;
    tick();
    #1;
    chk("t2_first_i", 64'(owner_o), 64'h1);
    mack_i = 1'b1;
    tick();
    isiz_i = 2'b00; mack_i = 1'b0;
    #1;
    chk("t2_gap", 64'(owner_o), 64'h0);
    tick();
    #1;
    chk("t2_d_owner", 64'(owner_o), 64'h2);
    chk("t2_d_mwe", 64'(mwe_o), 64'h1);
    chk("t2_d_mdat", mdat_o, 64'hDEAD);
    mack_i = 1'b1;
    tick();
    mack_i = 1'b0; isiz_i = 2'b10;
    tick();
    #1;
    chk("t2_rr_i", 64'(owner_o), 64'h1);
    mack_i = 1'b1;
    tick();
    isiz_i = 2'b00; mack_i = 1'b0;
    tick();

    // D stalls with I pending
    #1;
    chk("t3_d_owner", 64'(owner_o), 64'h2);
    isiz_i = 2'b10;
    for (int k = 0; k < (TMO ? 3 : 5); k++) begin
      #1;
      chk("t3_hold_owner", 64'(owner_o), 64'h2);
      chk("t3_hold_dack", 64'(dack_o), 64'h0);
      chk("t3_hold_iack", 64'(iack_o), 64'h0);
      tick();
    end
    mack_i = 1'b1;
    #1;
    chk("t3_dack", 64'(dack_o), 64'h1);
    tick();
    dsiz_i = 2'b00; mack_i = 1'b0;
    #1;
    chk("t3_gap", 64'(owner_o), 64'h0);
    tick();
    #1;
    chk("t3_i_owner", 64'(owner_o), 64'h1);

    // I withdraws while memory acks
    isiz_i = 2'b00; mack_i = 1'b1;
    #1;
    chk("t4_no_iack", 64'(iack_o), 64'h0);
    tick();
    mack_i = 1'b0;
    #1;
    chk("t4_idle", 64'(owner_o), 64'h0);
    isiz_i = 2'b10; dsiz_i = 2'b01;
    tick();
    #1;
    chk("t4_last_kept", 64'(owner_o), 64'h1);

    // Reset while D owns the port
    mack_i = 1'b1;
    tick();
    isiz_i = 2'b00; mack_i = 1'b0;
    tick();
    #1;
    chk("t5_d_owner", 64'(owner_o), 64'h2);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0; mack_i = 1'b1;
    #1;
    chk("t5_owner", 64'(owner_o), 64'h0);
    chk("t5_msiz", 64'(msiz_o), 64'h0);
    chk("t5_dack", 64'(dack_o), 64'h0);
    dsiz_i = 2'b00; mack_i = 1'b0; dwe_i = 1'b0;
    tick();

    // Grant timeout
    isiz_i = 2'b10;
    tick();
    for (int k = 0; k < 6; k++) begin
      mack_i = 1'b0;
      #1;
      chk("t6_ierr", 64'(ierr_o), 64'(TMO && k == 4));
      chk("t6_iack", 64'(iack_o), 64'h0);
      chk("t6_owner", 64'(owner_o), (TMO && k == 5) ? 64'h0 : 64'h1);
      tick();
    end
    isiz_i = 2'b00;
    tick();
    tick();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      if (g_iack || g_ierr) isiz_i = 2'b00;
      else if (isiz_i == 2'b00 && $urandom_range(2) == 0) begin
        isiz_i = 2'($urandom_range(3, 1));
        iadr_i = {$urandom, $urandom};
      end else if (isiz_i != 2'b00 && $urandom_range(24) == 0) isiz_i = 2'b00;
      if (g_dack || g_derr) dsiz_i = 2'b00;
      else if (dsiz_i == 2'b00 && $urandom_range(2) == 0) begin
        dsiz_i = 2'($urandom_range(3, 1));
        dadr_i = {$urandom, $urandom};
        ddat_i = {$urandom, $urandom};
        dwe_i  = 1'($urandom_range(1));
      end else if (dsiz_i != 2'b00 && $urandom_range(24) == 0) dsiz_i = 2'b00;
      mack_i  = ($urandom_range(2) == 0);
      mdat_i  = {$urandom, $urandom};
      reset_i = ($urandom_range(99) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between the CPU instruction-fetch master (I) and the load/store master (D).
- Sits between the CPU's I and D master interfaces and the single external bus master port.
- Grants the port to one master per transfer using a registered grant FSM with round-robin tie-break.
- The grant is held until the memory acknowledges.

Parameters:
- TIMEOUT_CYCLES, 255: cycles a grant may stay open without acknowledge. Used only with ARB_TIMEOUT_EN.
- TMR_W, 8: width of the timeout counter. Must satisfy TIMEOUT_CYCLES < 2^TMR_W.

Ports:
- clk_i  in  1  system clock; all state updates on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- iadr_i  in  64  I master address.
- isiz_i  in  2  I request size: 00 none, 01 byte, 10 word, 11 dword.
- iack_o  out  1  I transfer acknowledge.
- idat_o  out  32  I read data.
- ierr_o  out  1  I timeout error pulse.
- dadr_i  in  64  D master address.
- dsiz_i  in  2  D request size, same encoding as isiz_i.
- dwe_i  in  1  D write enable.
- ddat_i  in  64  D write data.
- dack_o  out  1  D transfer acknowledge.
- ddat_o  out  64  D read data.
- derr_o  out  1  D timeout error pulse.
- madr_o  out  64  shared port address.
- msiz_o  out  2  shared port size.
- mwe_o  out  1  shared port write enable.
- mdat_o  out  64  shared port write data.
- mack_i  in  1  shared port acknowledge.
- mdat_i  in  64  shared port read data.
- owner_o  out  2  diagnostic: 00 idle, 01 I, 10 D.

Behaviour:
- Request detection:
  - Request from I is isiz_i != 00.
  - Request from D is dsiz_i != 00.
  - Masters hold address, size and write data stable until their ack.
- FSM states: IDLE, OWN_I, OWN_D.
  - State register and last-granted flag `last` update on the rising edge of clk_i.
- Reset (reset_i=1 at a clock edge):
  - State = IDLE, last = D, timeout counter = 0.
  - Reset mid-transfer abandons the transfer immediately. No ack is forwarded in the cycle after reset.
- IDLE:
  - No request: stay in IDLE.
  - Only I requests: go to OWN_I. Only D requests: go to OWN_D.
  - Both request: grant the master not equal to `last`. After reset, I therefore wins the first tie.
  - Grant latency is 1 cycle: a request seen in IDLE drives the shared port on the next cycle.
- OWN_x:
  - madr_o, msiz_o, mwe_o, mdat_o come combinationally from owner x's live inputs.
  - For I: mwe_o=0 and mdat_o=0.
  - xack_o = mack_i. The other master's ack = 0.
  - On mack_i=1: set last = x, return to IDLE. There is exactly one idle cycle between transfers, and there is no back-to-back grant.
  - If the owner drops its size to 00 before ack (withdrawal): return to IDLE, do not change `last`, force xack_o = 0 that cycle.
- IDLE outputs: madr_o=0, msiz_o=00, mwe_o=0, mdat_o=0, both acks 0.
- Read data fan-out: idat_o = mdat_i[31:0] and ddat_o = mdat_i at all times. Masters sample data only on their ack.
- owner_o reflects the current state register. It is 00 out of reset.
- Reset values: all outputs 0 (idat_o and ddat_o follow mdat_i).
- Address and data pass through unmodified; the arbiter applies no alignment or size checks.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - The TMR_W-bit counter clears in IDLE and increments each cycle in OWN_x while mack_i=0.
  - When counter == TIMEOUT_CYCLES with mack_i=0, pulse xerr_o for exactly 1 cycle, force xack_o=0, return to IDLE and set last = x.
  - If mack_i arrives in the same cycle as expiry, the ack wins and no error is raised.
- Without the macro: no counter is built, ierr_o and derr_o are tied to 0, and a grant may wait forever.

Test Plan:
- Reset, then isiz_i=10, iadr_i=FFFF_FFFF_FFFF_FF00, D idle -> owner_o=01 one cycle later; madr_o=FFFF_FFFF_FFFF_FF00; msiz_o=10; mack_i=1 with mdat_i=0000_0013 -> iack_o=1, idat_o=0000_0013, owner_o=00 next cycle.
- Both request from reset (I adr 0x124, D adr 0x248, dwe_i=1, ddat_i=0xDEAD) -> I granted first, then after I's ack and one idle cycle D granted with mwe_o=1, mdat_o=0xDEAD; on a second simultaneous request I wins again (last=D).
- D owns the port, mack_i held 0 for 5 cycles -> dack_o=0 and iack_o=0 throughout; pending I request not granted until cycle after D's ack.
- I owns the port, isiz_i drops to 00 before ack while mack_i=1 that cycle -> iack_o=0, return to IDLE, `last` unchanged.
- reset_i=1 while OWN_D with mack_i=0 -> next cycle owner_o=00, msiz_o=00, dack_o=0.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, I granted, mack_i=0 -> ierr_o pulses once 4 cycles after grant, iack_o=0, then IDLE. Without the macro, ierr_o stays 0 and the grant persists.
